nn_param_stream_loader: RTL and testbench
=========================================

Name: nn_param_stream_loader

Overview:
- Write-side driver for the 24-byte neural-network parameter shift chain: 4 neurons, each with weights w0..w3, bias b and threshold th.
- Accepts parameter bytes from the host-side byte interface over a valid/ready handshake and emits one shift command (selector=01) plus data byte per accepted byte.
- Counts bytes, signals completion, and flags a stalled host with a timeout error.
- Sits between the host byte link (UART/SPI deserializer) and the parameter shift register.

Parameters:
NUM_PARAMS, 24, number of bytes in one complete parameter load
DATA_W, 8, parameter byte width
TIMEOUT_CYCLES, 1023, max idle cycles between accepted bytes in LOAD; 0 disables the timeout

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  single-cycle request to begin (or restart) a load
s_data  input  DATA_W  incoming parameter byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts s_data this cycle
data_out  output  DATA_W  byte presented to the shift chain
selector  output  2  shift chain command: 2'b01 = shift in data_out, 2'b00 = hold
busy  output  1  load in progress (LOAD or DRAIN)
done  output  1  full load completed; held until next start or reset
error  output  1  timeout occurred; held until next start or reset
byte_count  output  $clog2(NUM_PARAMS+1)  bytes accepted in the current load

Behaviour:
- Reset is synchronous, active-high; clock is clk. On reset: state=IDLE, data_out=0, selector=00, s_ready=0, busy=0, done=0, error=0, byte_count=0, timeout counter=0.
- All outputs are registered. The loader only ever drives selector 00 or 01.
- States: IDLE, LOAD, DRAIN, ERROR.
- IDLE:
  - s_ready=0; s_valid is ignored.
  - start -> LOAD; byte_count, timeout counter, done and error cleared.
- LOAD:
  - s_ready=1.
  - Handshake when s_valid && s_ready in cycle t: data_out<=s_data, selector=01 for cycle t+1 only, byte_count+1, timeout counter cleared.
  - Without a handshake: selector=00 next cycle, data_out holds, timeout counter +1.
  - Back-to-back handshakes produce selector=01 on consecutive cycles.
  - When the handshake takes byte_count to NUM_PARAMS -> DRAIN; s_ready drops the next cycle.
- DRAIN (one cycle):
  - selector=01 carries the last byte; s_ready=0.
  - Next cycle: IDLE, done=1, busy=0, selector=00.
- Timeout: in LOAD with TIMEOUT_CYCLES>0, when the timeout counter reaches TIMEOUT_CYCLES -> ERROR. In the next cycle error=1, busy=0, s_ready=0, selector=00.
- ERROR: holds until start, then behaves as start from IDLE.
- Byte order: the first accepted byte ends in w00 after NUM_PARAMS shifts. Host sends w00,w01,w02,w03,b0,th0,w10,...,b3,th3.
- start during LOAD or DRAIN aborts and restarts: byte_count=0, timeout counter=0, next state LOAD.
  - A handshake in the same cycle as start is discarded: no shift is issued and s_data is not captured.
  - Bytes already shifted are left in the chain; a full restart overwrites all NUM_PARAMS entries.
- Simultaneous timeout expiry and handshake in the same cycle: the handshake wins and no error is raised.
- Reset mid-load: returns immediately to reset values. No partial shift is issued after the reset cycle.
- byte_count saturates at NUM_PARAMS and holds until the next start.

Test Plan:
1. Reset, start, then 24 back-to-back bytes 0x01..0x18 -> selector=01 on exactly 24 consecutive cycles, data_out=0x01..0x18 in order, done=1 one cycle after the last shift, byte_count=24. Attached shift chain shows w00=0x01, b0=0x05, th0=0x06, th3=0x18.
2. Same load with s_valid low for 3 cycles after every 4th byte -> selector=00 during the gaps, data_out held, 24 shifts total, final chain contents identical to scenario 1, no error.
3. TIMEOUT_CYCLES=16; start, 5 bytes, then s_valid=0 -> error=1 after 16 idle cycles, s_ready=0, busy=0, byte_count=5, no further selector=01. New start plus 24 bytes -> error clears and done=1.
4. Start, 10 bytes, then start again with s_valid=1 in the same cycle -> that byte is not shifted and byte_count=0. 24 further bytes 0xA0..0xB7 -> chain w00=0xA0, th3=0xB7, done=1.
5. Reset asserted after 12 bytes, during a selector=01 cycle -> next cycle selector=00, data_out=0, busy=0, byte_count=0. s_valid is ignored until start.
6. s_valid=1 with data 0x55 in IDLE, no start -> s_ready=0 and selector stays 00 for 50 cycles; done and error stay 0.

Source files
------------

// File: rtl/nn_param_stream_loader.sv
// Write-side driver for the neural-network parameter shift chain: takes host bytes over
// valid/ready and issues one shift command per accepted byte, with done and stall-timeout flags.
module nn_param_stream_loader #(
    parameter int NUM_PARAMS     = 24,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [DATA_W-1:0]                 s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [DATA_W-1:0]                 data_out,
    output logic [1:0]                        selector,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [$clog2(NUM_PARAMS+1)-1:0]   byte_count
);

    localparam int CW = $clog2(NUM_PARAMS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_M1    = CW'(NUM_PARAMS - 1);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    SEL_HOLD   = 2'b00;
    localparam logic [1:0]    SEL_SHIFT  = 2'b01;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ERR} state_t;

    state_t        state;
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            data_out   <= '0;
            selector   <= SEL_HOLD;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
            idle_cnt   <= '0;
        end else if (start) begin
            // Restart from any state; a byte offered alongside start is dropped.
            state      <= LOAD;
            selector   <= SEL_HOLD;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid && s_ready) begin
                        data_out   <= s_data;
                        selector   <= SEL_SHIFT;
                        byte_count <= byte_count + CW'(1);
                        idle_cnt   <= '0;
                        if (byte_count == LAST_M1) begin
                            state   <= DRAIN;
                            s_ready <= 1'b0;
                        end
                    end else begin
                        selector <= SEL_HOLD;
                        if (TIMEOUT_CYCLES > 0) begin
                            idle_cnt <= idle_cnt + TW'(1);
                            if (idle_cnt == TIMEOUT_M1) begin
                                state   <= ERR;
                                error   <= 1'b1;
                                busy    <= 1'b0;
                                s_ready <= 1'b0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    state    <= IDLE;
                    selector <= SEL_HOLD;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                IDLE, ERR: begin
                    selector <= SEL_HOLD;
                end
                default: begin
                    state    <= IDLE;
                    selector <= SEL_HOLD;
                    s_ready  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_param_stream_loader.sv
// Self-checking bench for nn_param_stream_loader: cycle model of the load protocol,
// an attached 24-entry shift chain, and literal spot checks.
module tb_nn_param_stream_loader;

    localparam int N  = 24;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] data_out;
    logic [1:0] selector;
    logic       busy, done, error;
    logic [4:0] byte_count;

    int checks = 0;
    int errors = 0;

    nn_param_stream_loader #(.NUM_PARAMS(N), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .data_out(data_out), .selector(selector), .busy(busy),
        .done(done), .error(error), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: accepting window, byte tally, idle tally and flags.
    bit       m_on = 0;
    bit       accepting = 0, draining = 0;
    int       got = 0, idle = 0;
    bit [7:0] m_dout = 0;
    bit [1:0] m_sel = 0;
    bit       m_busy = 0, m_done = 0, m_err = 0;

    always @(posedge clk) begin
        m_on = 1;
        if (reset) begin
            accepting = 0; draining = 0; got = 0; idle = 0;
            m_dout = 0; m_sel = 0; m_busy = 0; m_done = 0; m_err = 0;
        end else if (start) begin
            accepting = 1; draining = 0; got = 0; idle = 0;
            m_sel = 0; m_busy = 1; m_done = 0; m_err = 0;
        end else if (draining) begin
            draining = 0; m_sel = 0; m_busy = 0; m_done = 1;
        end else if (accepting) begin
            if (s_valid) begin
                m_dout = s_data; m_sel = 1; got++; idle = 0;
                if (got == N) begin accepting = 0; draining = 1; end
            end else begin
                m_sel = 0; idle++;
                if (idle == TO) begin accepting = 0; m_busy = 0; m_err = 1; end
            end
        end else begin
            m_sel = 0;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("s_ready", 32'(s_ready), 32'(accepting));
            chk("data_out", 32'(data_out), 32'(m_dout));
            chk("selector", 32'(selector), 32'(m_sel));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            chk("byte_count", 32'(byte_count), 32'(got));
        end
    end

    // External shift chain: index 0 is w00, index 23 is th3.
    logic [7:0] chain [N];
    int shifts = 0;
    always @(posedge clk) begin
        if (selector == 2'b01) begin
            for (int i = 0; i < N - 1; i++) chain[i] <= chain[i+1];
            chain[N-1] <= data_out;
            shifts++;
        end
    end

    task automatic cyc(input logic st, input logic v, input logic [7:0] d);
        start = st; s_valid = v; s_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    int s0;

    initial begin
        repeat (3) cyc(0, 0, 0);
        reset = 1'b0;
        chk("reset_selector", 32'(selector), 32'd0);
        chk("reset_count", 32'(byte_count), 32'd0);

        // 1: back-to-back full load
        s0 = shifts;
        cyc(1, 0, 0);
        for (int i = 1; i <= N; i++) cyc(0, 1, 8'(i));
        chk("s1_drain_sel", 32'(selector), 32'd1);
        chk("s1_drain_ready", 32'(s_ready), 32'd0);
        cyc(0, 0, 0);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_count", 32'(byte_count), 32'd24);
        cyc(0, 0, 0);
        chk("s1_shifts", 32'(shifts - s0), 32'd24);
        chk("s1_w00", 32'(chain[0]), 32'h01);
        chk("s1_b0", 32'(chain[4]), 32'h05);
        chk("s1_th0", 32'(chain[5]), 32'h06);
        chk("s1_th3", 32'(chain[23]), 32'h18);

        // 2: gaps of 3 cycles after every 4th byte
        for (int i = 0; i < N; i++) chain[i] = 8'hEE;
        s0 = shifts;
        cyc(1, 0, 0);
        for (int i = 1; i <= N; i++) begin
            cyc(0, 1, 8'(i));
            if (i % 4 == 0 && i < N) repeat (3) cyc(0, 0, 8'hCC);
        end
        repeat (2) cyc(0, 0, 0);
        chk("s2_shifts", 32'(shifts - s0), 32'd24);
        chk("s2_w00", 32'(chain[0]), 32'h01);
        chk("s2_th3", 32'(chain[23]), 32'h18);
        chk("s2_error", 32'(error), 32'd0);
        chk("s2_done", 32'(done), 32'd1);

        // 3: host stall after 5 bytes
        cyc(1, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 1, 8'h40 + 8'(i));
        s0 = shifts;
        repeat (15) cyc(0, 0, 0);
        chk("s3_no_err_yet", 32'(error), 32'd0);
        cyc(0, 0, 0);
        chk("s3_error", 32'(error), 32'd1);
        chk("s3_ready", 32'(s_ready), 32'd0);
        chk("s3_busy", 32'(busy), 32'd0);
        chk("s3_count", 32'(byte_count), 32'd5);
        repeat (5) cyc(0, 1, 8'h99);
        chk("s3_shifts", 32'(shifts - s0), 32'd1);
        cyc(1, 0, 0);
        chk("s3_err_clear", 32'(error), 32'd0);
        for (int i = 0; i < N; i++) cyc(0, 1, 8'h60 + 8'(i));
        repeat (2) cyc(0, 0, 0);
        chk("s3_done", 32'(done), 32'd1);

        // 4: restart mid-load with a byte offered alongside start
        cyc(1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 8'h30 + 8'(i));
        cyc(1, 1, 8'h77);
        chk("s4_sel", 32'(selector), 32'd0);
        chk("s4_count", 32'(byte_count), 32'd0);
        chk("s4_dout_held", 32'(data_out), 32'h39);
        for (int i = 0; i < N; i++) cyc(0, 1, 8'hA0 + 8'(i));
        repeat (2) cyc(0, 0, 0);
        chk("s4_w00", 32'(chain[0]), 32'hA0);
        chk("s4_th3", 32'(chain[23]), 32'hB7);
        chk("s4_done", 32'(done), 32'd1);

        // 5: reset during a shift cycle
        cyc(1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 8'h10 + 8'(i));
        chk("s5_pre_sel", 32'(selector), 32'd1);
        reset = 1'b1;
        cyc(0, 1, 8'h22);
        reset = 1'b0;
        chk("s5_sel", 32'(selector), 32'd0);
        chk("s5_dout", 32'(data_out), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_count", 32'(byte_count), 32'd0);
        s0 = shifts;
        repeat (10) cyc(0, 1, 8'h33);
        chk("s5_ignored", 32'(shifts - s0), 32'd0);

        // 6: valid data in IDLE without start
        s0 = shifts;
        repeat (50) cyc(0, 1, 8'h55);
        chk("s6_shifts", 32'(shifts - s0), 32'd0);
        chk("s6_ready", 32'(s_ready), 32'd0);
        chk("s6_done", 32'(done), 32'd0);
        chk("s6_error", 32'(error), 32'd0);

        cyc(0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
